// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: one whole-cacheline memory port.
//   address/read/write/wdata flow from requester to responder,
//   rdata/resp flow back.  A cache (or the arbiter facing memory) uses
//   the master modport; the side that serves lines uses the slave modport.
//   The I-cache port never writes: its write/wdata are tied low by the owner.
interface pmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (output address, read, write, wdata, input rdata, resp);
    modport slave  (input address, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one cacheline memory port between the I-cache and
// the D-cache.  Whole-line transactions are serialised; the response is
// routed back to whichever cache was granted.
//
// Ports:
//   clk, rst  - clock; synchronous active-high reset
//   i_bus     - slave port facing the I-cache (read only)
//   d_bus     - slave port facing the D-cache (read or writeback)
//   mem_bus   - master port facing the cacheline adaptor / main memory
//
// Optional feature (macro ARB_RR_EN):
//   defined   - round-robin on contention, tracked by a last-grant flop
//               that resets to "D" so the I-cache wins the first tie.
//   undefined - fixed D-over-I priority.
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic           clk,
    input  logic           rst,
    pmem_arbiter_if.slave  i_bus,
    pmem_arbiter_if.slave  d_bus,
    pmem_arbiter_if.master mem_bus
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              d_pend, i_pend, pick_d;
    logic              i_resp, d_resp, busy;
`ifdef ARB_RR_EN
    logic              last_d_q, last_d_d;  // 1: most recent grant went to D
`endif

    // I port has no write path; these inputs are intentionally ignored.
    logic unused_i_wr;
    assign unused_i_wr = ^{i_bus.write, i_bus.wdata};

    assign d_pend = d_bus.read | d_bus.write;
    assign i_pend = i_bus.read;

`ifdef ARB_RR_EN
    assign pick_d = d_pend & (~i_pend | ~last_d_q);
`else
    assign pick_d = d_pend;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        i_resp  = 1'b0;
        d_resp  = 1'b0;
`ifdef ARB_RR_EN
        last_d_d = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = D_BUSY;
                    addr_d  = d_bus.address;
                    wdata_d = d_bus.wdata;
                    // read+write together is treated as a writeback
                    wr_d    = d_bus.write;
                    rd_d    = d_bus.read & ~d_bus.write;
`ifdef ARB_RR_EN
                    last_d_d = 1'b1;
`endif
                end else if (i_pend) begin
                    state_d = I_BUSY;
                    addr_d  = i_bus.address;
                    wdata_d = '0;
                    wr_d    = 1'b0;
                    rd_d    = 1'b1;
`ifdef ARB_RR_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            I_BUSY: begin
                if (mem_bus.resp) begin
                    i_resp  = 1'b1;
                    state_d = DONE;
                end
            end
            D_BUSY: begin
                if (mem_bus.resp) begin
                    d_resp  = 1'b1;
                    state_d = DONE;
                end
            end
            // Bubble: a cache still holding its request for one cycle after
            // resp (tag/valid update) must not be re-granted.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef ARB_RR_EN
            last_d_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef ARB_RR_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    // Memory side only ever sees latched request values.
    assign busy            = (state_q == I_BUSY) || (state_q == D_BUSY);
    assign mem_bus.address = addr_q;
    assign mem_bus.wdata   = wdata_q;
    assign mem_bus.read    = busy & rd_q;
    assign mem_bus.write   = busy & wr_q;

    // Line data goes to both caches; only resp qualifies it.
    assign i_bus.rdata = mem_bus.rdata;
    assign d_bus.rdata = mem_bus.rdata;
    assign i_bus.resp  = i_resp;
    assign d_bus.resp  = d_resp;
endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [31:0]  A_I = 32'h0000_1040;
    localparam logic [31:0]  A_D = 32'h0000_3000;
    localparam logic [31:0]  F   = RR ? A_I : A_D;   // first winner on contention
    localparam logic [31:0]  S   = RR ? A_D : A_I;   // second
    localparam logic [255:0] LA5 = {32{8'hA5}};
    localparam logic [255:0] R5A = {32{8'h5A}};
    localparam logic [255:0] RC3 = {32{8'hC3}};
    localparam logic [255:0] WD1 = {8{32'h1234_5678}};
    localparam logic [255:0] WD2 = {8{32'hCAFE_F00D}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pmem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) i_if ();
    pmem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) d_if ();
    pmem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) m_if ();

    pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst), .i_bus(i_if), .d_bus(d_if), .mem_bus(m_if)
    );

    typedef struct {
        logic rst, ird; logic [31:0] ia;
        logic drd, dwr; logic [31:0] da; logic [255:0] dwd;
        logic mresp; logic [255:0] mrd;
        logic erd, ewr; logic [31:0] ea; logic [255:0] ewd; logic eir, edr;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int idx, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
    endtask

    function automatic vec_t mk(logic r, logic ird, logic [31:0] ia, logic drd, logic dwr,
                                logic [31:0] da, logic [255:0] dwd, logic mresp, logic [255:0] mrd,
                                logic erd, logic ewr, logic [31:0] ea, logic [255:0] ewd,
                                logic eir, logic edr);
        vec_t v;
        v.rst = r; v.ird = ird; v.ia = ia; v.drd = drd; v.dwr = dwr; v.da = da; v.dwd = dwd;
        v.mresp = mresp; v.mrd = mrd; v.erd = erd; v.ewr = ewr; v.ea = ea; v.ewd = ewd;
        v.eir = eir; v.edr = edr;
        return v;
    endfunction

    vec_t tbl[$];
    logic [31:0] alt_exp[3];

    initial begin
        rst = 1'b1;
        i_if.address = '0; i_if.read = 1'b0; i_if.write = 1'b0; i_if.wdata = '0;
        d_if.address = '0; d_if.read = 1'b0; d_if.write = 1'b0; d_if.wdata = '0;
        m_if.rdata = '0; m_if.resp = 1'b0;

        // one entry per cycle: inputs for the cycle, outputs expected in it
        tbl.push_back(mk(1,0,0,   0,0,0,0,          0,0,   0,0,0,0,        0,0));   // reset
        tbl.push_back(mk(0,1,A_I, 0,0,0,0,          0,0,   0,0,0,0,        0,0));   // I req seen
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0,1,A_I, 0,0,0,0,      0,0,   1,0,A_I,0,      0,0));   // I busy
        tbl.push_back(mk(0,1,A_I, 0,0,0,0,          1,LA5, 1,0,A_I,0,      1,0));   // I resp
        tbl.push_back(mk(0,1,A_I, 0,0,0,0,          0,0,   0,0,A_I,0,      0,0));   // held in DONE
        tbl.push_back(mk(0,0,0,   0,0,0,0,          1,0,   0,0,A_I,0,      0,0));   // stray resp
        tbl.push_back(mk(0,0,0,   0,1,32'h2000,WD1, 0,0,   0,0,A_I,0,      0,0));   // D writeback
        tbl.push_back(mk(0,0,0,   0,0,32'hDEAD,0,   0,0,   0,1,32'h2000,WD1,0,0));  // req dropped
        tbl.push_back(mk(0,0,0,   0,0,32'hDEAD,0,   0,0,   0,1,32'h2000,WD1,0,0));
        tbl.push_back(mk(0,0,0,   0,0,32'hDEAD,0,   1,0,   0,1,32'h2000,WD1,0,1));
        tbl.push_back(mk(0,0,0,   0,0,0,0,          0,0,   0,0,32'h2000,WD1,0,0));
        tbl.push_back(mk(0,1,A_I, 1,0,A_D,0,        0,0,   0,0,32'h2000,WD1,0,0));  // contention
        tbl.push_back(mk(0,1,A_I, 1,0,A_D,0,        0,0,   1,0,F,0,        0,0));
        tbl.push_back(mk(0,1,A_I, 1,0,A_D,0,        1,R5A, 1,0,F,0,        RR,!RR));
        tbl.push_back(mk(0,1,A_I, 1,0,A_D,0,        0,0,   0,0,F,0,        0,0));   // DONE
        tbl.push_back(mk(0,!RR,A_I, RR,0,A_D,0,     0,0,   0,0,F,0,        0,0));   // IDLE, loser
        tbl.push_back(mk(0,!RR,A_I, RR,0,A_D,0,     0,0,   1,0,S,0,        0,0));
        tbl.push_back(mk(0,!RR,A_I, RR,0,A_D,0,     1,RC3, 1,0,S,0,        !RR,RR));
        tbl.push_back(mk(0,0,0,   0,0,0,0,          0,0,   0,0,S,0,        0,0));
        tbl.push_back(mk(0,0,0,   1,1,32'h4000,WD2, 0,0,   0,0,S,0,        0,0));   // rd+wr
        tbl.push_back(mk(0,0,0,   1,1,32'h4000,WD2, 0,0,   0,1,32'h4000,WD2,0,0));
        tbl.push_back(mk(0,0,0,   1,1,32'h4000,WD2, 1,0,   0,1,32'h4000,WD2,0,1));
        tbl.push_back(mk(0,0,0,   0,0,0,0,          0,0,   0,0,32'h4000,WD2,0,0));
        tbl.push_back(mk(0,1,32'h5000, 0,0,0,0,     0,0,   0,0,32'h4000,WD2,0,0));  // I req
        tbl.push_back(mk(1,1,32'h5000, 0,0,0,0,     0,0,   1,0,32'h5000,0, 0,0));   // rst in busy
        tbl.push_back(mk(0,0,0,   0,0,0,0,          1,0,   0,0,0,0,        0,0));   // abandoned

        foreach (tbl[n]) begin
            @(negedge clk);
            rst = tbl[n].rst;
            i_if.read = tbl[n].ird; i_if.address = tbl[n].ia;
            d_if.read = tbl[n].drd; d_if.write = tbl[n].dwr;
            d_if.address = tbl[n].da; d_if.wdata = tbl[n].dwd;
            m_if.resp = tbl[n].mresp; m_if.rdata = tbl[n].mrd;
            #1;
            chk("mem_read",    n, m_if.read,    tbl[n].erd);
            chk("mem_write",   n, m_if.write,   tbl[n].ewr);
            chk("mem_address", n, m_if.address, tbl[n].ea);
            chk("mem_wdata",   n, m_if.wdata,   tbl[n].ewd);
            chk("i_resp",      n, i_if.resp,    tbl[n].eir);
            chk("d_resp",      n, d_if.resp,    tbl[n].edr);
            chk("i_rdata",     n, i_if.rdata,   tbl[n].mrd);
            chk("d_rdata",     n, d_if.rdata,   tbl[n].mrd);
        end

        // Repeated contention with both requests held throughout.
        alt_exp[0] = RR ? A_I : A_D;
        alt_exp[1] = A_D;
        alt_exp[2] = RR ? A_I : A_D;
        @(negedge clk);
        m_if.resp = 1'b0; m_if.rdata = '0;
        i_if.read = 1'b1; i_if.address = A_I;
        d_if.read = 1'b1; d_if.write = 1'b0; d_if.address = A_D; d_if.wdata = '0;
        for (int k = 0; k < 3; k++) begin
            logic got;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk); #1;
                if (m_if.read) got = 1'b1;
            end
            chk("alt_grant_seen", k, got, 1'b1);
            if (got) begin
                chk("alt_address", k, m_if.address, alt_exp[k]);
                m_if.resp = 1'b1;
                #1;
                chk("alt_i_resp", k, i_if.resp, alt_exp[k] == A_I);
                chk("alt_d_resp", k, d_if.resp, alt_exp[k] == A_D);
                @(posedge clk); #1;
                m_if.resp = 1'b0;
            end
        end
        i_if.read = 1'b0; d_if.read = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
Two-master, one-slave arbiter sharing the single physical-memory (cacheline) port between the instruction cache and the data cache. Sits between the two L1 caches and the cacheline adaptor / main memory. Serialises whole-line transactions (256-bit read or write) and routes the response back to the granted cache. Caches hold requests until they see their own resp.

Parameters:
ADDR_W, 32, physical address width
LINE_W, 256, cacheline width in bits

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_pmem_address  in  ADDR_W  I-cache line address (line-aligned)
i_pmem_read  in  1  I-cache line read request
i_pmem_rdata  out  LINE_W  line data to I-cache
i_pmem_resp  out  1  I-cache transaction complete
d_pmem_address  in  ADDR_W  D-cache line address
d_pmem_read  in  1  D-cache line read request
d_pmem_write  in  1  D-cache line writeback request
d_pmem_wdata  in  LINE_W  D-cache writeback data
d_pmem_rdata  out  LINE_W  line data to D-cache
d_pmem_resp  out  1  D-cache transaction complete
mem_address  out  ADDR_W  address to memory
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_wdata  out  LINE_W  write data to memory
mem_rdata  in  LINE_W  read data from memory
mem_resp  in  1  memory transaction complete

Behaviour:
- States: IDLE, I_BUSY, D_BUSY, DONE. Reset -> IDLE.
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, i_pmem_resp=0, d_pmem_resp=0.
- IDLE: samples requests at clock edge. d pending = d_pmem_read|d_pmem_write; i pending = i_pmem_read. Default priority: D over I. Grant -> D_BUSY or I_BUSY; no request -> stay IDLE.
- On grant edge: latch address, op (read/write), wdata into internal registers; mem_* driven only from latched values, never directly from requester inputs.
- I_BUSY: mem_read=1, mem_write=0. D_BUSY: mem_read=latched read, mem_write=latched write. Strobes held constant until mem_resp.
- d_pmem_read and d_pmem_write both high at grant: treated as write (mem_write=1, mem_read=0).
- mem_resp in X_BUSY: same cycle, x_pmem_resp=1 (combinational), other resp stays 0; next state DONE; mem_read/mem_write go 0 at DONE.
- i_pmem_rdata and d_pmem_rdata: both wired to mem_rdata continuously; only the resp qualifies them.
- DONE: one-cycle bubble, no grant, all strobes and resps 0. Absorbs requester still asserting read the cycle after resp (cache updating tag/valid). DONE -> IDLE unconditionally.
- Latency: request seen at edge N -> strobe asserted in cycle N+1; resp forwarded in the mem_resp cycle; earliest new grant 2 cycles after resp.
- mem_resp outside BUSY: ignored, no resp forwarded.
- Requester dropping request mid-transaction: ignored; transaction completes and resp is pulsed anyway.
- rst mid-transaction: next cycle IDLE, strobes 0, transaction abandoned; memory side must be reset concurrently.

Optional Feature:
ARB_RR_EN: defined -> round-robin on contention. last_grant register (reset = D, so I wins first tie); when both pending in IDLE, grant the master not in last_grant; last_grant updates on every grant. Undefined -> fixed D-over-I priority, no last_grant register.

Test Plan:
- I read alone: i_pmem_read=1, addr 0x0000_1040; mem_resp after 5 cycles with rdata 0xA5..A5 -> mem_read=1, mem_address 0x1040 from cycle 1; i_pmem_resp pulsed 1 cycle with i_pmem_rdata 0xA5..A5; d_pmem_resp stays 0.
- D writeback: d_pmem_write=1, addr 0x0000_2000, wdata 0x1234..; mem_resp at cycle 4 -> mem_write=1 with those values, mem_read=0; d_pmem_resp 1 cycle.
- Contention: i and d read asserted same cycle -> D granted first (no macro); I granted 2 cycles after D's resp. With ARB_RR_EN: I first, then D; repeat contention -> strict alternation.
- Held request after resp: i_pmem_read held 1 cycle after i_pmem_resp -> no second mem_read issued (DONE bubble).
- Reset mid-transaction: rst in I_BUSY before mem_resp -> next cycle mem_read=0, state IDLE, no resp pulsed.
- Read+write both high from D: mem_write=1, mem_read=0 throughout.
